// File: rtl/zxuno_regbus_arbiter.sv
// ============================================================================
// Module      : zxuno_regbus_arbiter
// Description : Shares the ZX-Uno internal register bus between the Z80
//               index/data I/O ports and an internal auxiliary master.
//               The CPU has priority; an aux access is an atomic 2-cycle job.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zxuno_regbus_arbiter #(
  parameter logic [15:0] IOADDR = 16'hFC3B,
  parameter logic [15:0] IODATA = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst,
  // Z80 side
  input  logic [15:0] cpu_a,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  // auxiliary master
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [7:0]  aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [7:0]  aux_rdata,
  // register bus towards peripherals
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_dout,
  input  logic [7:0]  reg_dout,
  input  logic        reg_oe_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_RD   = 3'd1;
  localparam logic [2:0] S_CPU_WR   = 3'd2;
  localparam logic [2:0] S_CPU_WAIT = 3'd3;
  localparam logic [2:0] S_AUX_ADDR = 3'd4;
  localparam logic [2:0] S_AUX_CAP  = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_idx;
  logic       r_idx_wr_d;
  logic       r_cpu_hold;
  logic       w_idx_sel;
  logic       w_idx_wr;
  logic       w_idx_rd;
  logic       w_dat_rd;
  logic       w_dat_wr;
  logic       w_rd_go;
  logic       w_wr_go;
  logic [7:0] w_reg_data;

  assign w_idx_sel  = !cpu_iorq_n && (cpu_a == IOADDR);
  assign w_idx_wr   = w_idx_sel && !cpu_wr_n;
  assign w_idx_rd   = w_idx_sel && !cpu_rd_n;
  assign w_dat_rd   = !cpu_iorq_n && !cpu_rd_n && (cpu_a == IODATA);
  assign w_dat_wr   = !cpu_iorq_n && !cpu_wr_n && (cpu_a == IODATA);
  // A data-port strobe that straddled a reset is ignored until it ends.
  assign w_rd_go    = w_dat_rd && !r_cpu_hold;
  assign w_wr_go    = w_dat_wr && !r_cpu_hold;
  // Undriven wired bus reads back as all ones.
  assign w_reg_data = reg_oe_n ? 8'hFF : reg_dout;

  // Index register: one load on the first cycle of each CPU index write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 8'h00;
      r_idx_wr_d <= w_idx_wr;
    end else begin
      r_idx_wr_d <= w_idx_wr;
      if (w_idx_wr && !r_idx_wr_d) begin
        r_idx <= cpu_din;
      end
    end
  end

  // Block replay of a CPU data access that was in flight across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_hold <= w_dat_rd || w_dat_wr;
    end else if (!w_dat_rd && !w_dat_wr) begin
      r_cpu_hold <= 1'b0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; CPU data-port accesses win over aux requests.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_go) begin
          w_state_nxt = S_CPU_RD;
        end else if (w_wr_go) begin
          w_state_nxt = S_CPU_WR;
        end else if (aux_req) begin
          w_state_nxt = S_AUX_ADDR;
        end
      end
      S_CPU_RD:   if (!w_dat_rd) w_state_nxt = S_IDLE;
      S_CPU_WR:   w_state_nxt = S_CPU_WAIT;
      S_CPU_WAIT: if (!w_dat_wr) w_state_nxt = S_IDLE;
      S_AUX_ADDR: w_state_nxt = S_AUX_CAP;
      S_AUX_CAP:  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from the current state.
  always_comb begin
    zxuno_addr  = r_idx;
    zxuno_dout  = 8'h00;
    zxuno_regrd = 1'b0;
    zxuno_regwr = 1'b0;
    aux_gnt     = 1'b0;
    aux_done    = 1'b0;
    cpu_oe_n    = 1'b1;
    cpu_dout    = 8'hFF;
    case (r_state)
      S_CPU_RD: begin
        zxuno_regrd = 1'b1;
        cpu_oe_n    = 1'b0;
        cpu_dout    = w_reg_data;
      end
      S_CPU_WR: begin
        zxuno_dout  = cpu_din;
        zxuno_regwr = 1'b1;
      end
      S_AUX_ADDR: begin
        aux_gnt    = 1'b1;
        zxuno_addr = aux_addr;
        if (aux_we) begin
          zxuno_dout  = aux_wdata;
          zxuno_regwr = 1'b1;
        end else begin
          zxuno_regrd = 1'b1;
        end
      end
      S_AUX_CAP: begin
        aux_gnt     = 1'b1;
        aux_done    = 1'b1;
        zxuno_addr  = aux_addr;
        zxuno_regrd = !aux_we;
        zxuno_dout  = aux_we ? aux_wdata : 8'h00;
      end
      default: begin
        zxuno_addr = r_idx;
      end
    endcase
    // Index readback is independent of bus ownership.
    if (w_idx_rd) begin
      cpu_oe_n = 1'b0;
      cpu_dout = r_idx;
    end
  end

  // Aux read capture; value holds until the next aux read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      aux_rdata <= 8'h00;
    end else if ((r_state == S_AUX_CAP) && !aux_we) begin
      aux_rdata <= w_reg_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zxuno_regbus_arbiter.sv
// ============================================================================
// Module      : tb_zxuno_regbus_arbiter
// Description : Directed cycle vectors plus randomized transactions checked
//               against a register-file model of the peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zxuno_regbus_arbiter;

  localparam logic [15:0] IOADDR = 16'hFC3B;
  localparam logic [15:0] IODATA = 16'hFD3B;
  localparam logic [2:0]  CI = 3'b111;  // {iorq_n, rd_n, wr_n} idle
  localparam logic [2:0]  CR = 3'b001;  // IN
  localparam logic [2:0]  CW = 3'b010;  // OUT

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic        cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_oe_n;
  logic        aux_req, aux_we, aux_gnt, aux_done;
  logic [7:0]  aux_addr, aux_wdata, aux_rdata;
  logic [7:0]  zxuno_addr, zxuno_dout, reg_dout;
  logic        zxuno_regrd, zxuno_regwr, reg_oe_n;

  logic        tb_dir;
  logic [7:0]  d_rdout;
  logic        d_roe;
  logic [7:0]  pmem   [256];
  logic [7:0]  shadow [256];
  logic [7:0]  m_idx;
  logic        mon_en = 1'b0;
  logic        prev_wr = 1'b0;
  int          wr_seen = 0;
  int          wr_exp  = 0;
  int          tests   = 0;
  int          failed  = 0;

  always #5 clk = ~clk;

  zxuno_regbus_arbiter #(.IOADDR(IOADDR), .IODATA(IODATA)) dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_oe_n(cpu_oe_n),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_done(aux_done), .aux_rdata(aux_rdata),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .zxuno_dout(zxuno_dout), .reg_dout(reg_dout), .reg_oe_n(reg_oe_n)
  );

  // Peripheral model: registers below 0xC0 respond, the rest float high.
  always_comb begin
    if (tb_dir) begin
      reg_oe_n = d_roe;
      reg_dout = d_rdout;
    end else begin
      reg_oe_n = !(zxuno_regrd && (zxuno_addr < 8'hC0));
      reg_dout = reg_oe_n ? 8'h00 : pmem[zxuno_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) pmem[i] <= 8'(i * 37 + 11);
    end else if (!tb_dir && zxuno_regwr && (zxuno_addr < 8'hC0)) begin
      pmem[zxuno_addr] <= zxuno_dout;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus-protocol invariants checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_overlap", 16'(zxuno_regrd & zxuno_regwr), 16'd0);
      chk("regwr_width", 16'(zxuno_regwr & prev_wr), 16'd0);
      prev_wr <= zxuno_regwr;
      if (zxuno_regwr && !tb_dir) wr_seen <= wr_seen + 1;
    end
  end

  typedef struct packed {
    logic        rst;
    logic [2:0]  cpu;
    logic [15:0] a;
    logic [7:0]  din;
    logic        areq, awe;
    logic [7:0]  aaddr, awd, rdout;
    logic        roe_n, chk;
    logic        e_oe_n;
    logic [7:0]  e_dout, e_zaddr;
    logic [1:0]  e_rdwr;
    logic [7:0]  e_zdout;
    logic        e_gnt, e_done;
    logic [7:0]  e_ardata;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [15:0] a, input logic [7:0] din,
                              input logic areq, input logic awe, input logic [7:0] aaddr, input logic [7:0] awd,
                              input logic [7:0] rdout, input logic roe_n, input logic ck,
                              input logic e_oe_n, input logic [7:0] e_dout, input logic [7:0] e_zaddr,
                              input logic [1:0] e_rdwr, input logic [7:0] e_zdout, input logic e_gnt,
                              input logic e_done, input logic [7:0] e_ardata);
    vec_t v;
    v = '{r, c, a, din, areq, awe, aaddr, awd, rdout, roe_n, ck,
          e_oe_n, e_dout, e_zaddr, e_rdwr, e_zdout, e_gnt, e_done, e_ardata};
    return v;
  endfunction

  function automatic vec_t idle(input logic [7:0] zaddr, input logic [7:0] ard);
    return mk(1'b0, CI, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1,
              1'b1, 8'hFF, zaddr, 2'b00, 8'h00, 1'b0, 1'b0, ard);
  endfunction

  function automatic logic [7:0] expv(input logic [7:0] ad);
    return (ad < 8'hC0) ? shadow[ad] : 8'hFF;
  endfunction

  task automatic cpu_out(input logic [15:0] port, input logic [7:0] d, input int len);
    cpu_a = port; cpu_din = d; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (len) @(posedge clk);
    #1; cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1; cpu_a = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic cpu_in(input logic [15:0] port, input int len, output logic [7:0] d, output logic oe);
    cpu_a = port; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (len - 1) @(posedge clk);
    @(negedge clk); d = cpu_dout; oe = cpu_oe_n;
    @(posedge clk); #1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_a = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic aux_op(input logic we, input logic [7:0] ad, input logic [7:0] wd,
                        output logic [7:0] rd, output int gn);
    bit seen;
    seen = 1'b0; gn = 0;
    aux_req = 1'b1; aux_we = we; aux_addr = ad; aux_wdata = wd;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (aux_gnt) gn++;
      if (aux_done) seen = 1'b1;
    end
    chk("aux_done_seen", 16'(seen), 16'd1);
    @(posedge clk); #1;
    aux_req = 1'b0;
    rd = aux_rdata;
  endtask

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, v2, ad, rd, rd2;
    logic       oe, oe2, cw;
    int         op, gn, lw, lr;
    vec_t       t;

    // ---------------- directed vectors, one per clock ----------------
    tv.push_back(idle(8'h00, 8'h00));                                                                               // 0 reset state
    tv.push_back(mk(0, CW, IOADDR, 8'hFE, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 8'h00, 0, 0, 8'h00));         // 1 OUT idx
    tv.push_back(mk(0, CW, IOADDR, 8'hFE, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));         // 2
    tv.push_back(mk(0, CW, IOADDR, 8'h11, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));         // 3 no reload
    tv.push_back(idle(8'hFE, 8'h00));                                                                               // 4
    tv.push_back(mk(0, CW, IODATA, 8'h5A, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));         // 5 OUT data
    tv.push_back(mk(0, CW, IODATA, 8'h5A, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b01, 8'h5A, 0, 0, 8'h00));         // 6 regwr
    tv.push_back(mk(0, CW, IODATA, 8'h5A, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));         // 7 wait
    tv.push_back(idle(8'hFE, 8'h00));                                                                               // 8
    tv.push_back(idle(8'hFE, 8'h00));                                                                               // 9
    tv.push_back(mk(0, CR, IODATA, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));     // 10 IN data
    tv.push_back(mk(0, CR, IODATA, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 1, 0, 8'h5A, 8'hFE, 2'b10, 8'h00, 0, 0, 8'h00));     // 11
    tv.push_back(mk(0, CR, IODATA, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 1, 0, 8'h5A, 8'hFE, 2'b10, 8'h00, 0, 0, 8'h00));     // 12
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));          // 13 strobe tail
    tv.push_back(idle(8'hFE, 8'h00));                                                                               // 14
    tv.push_back(mk(0, CW, IOADDR, 8'h33, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'hFE, 2'b00, 8'h00, 0, 0, 8'h00));         // 15 idx 33
    tv.push_back(idle(8'h33, 8'h00));                                                                               // 16
    tv.push_back(mk(0, CR, IODATA, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h00));     // 17 no periph
    tv.push_back(mk(0, CR, IODATA, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'hFF, 8'h33, 2'b10, 8'h00, 0, 0, 8'h00));     // 18
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h00));          // 19 strobe tail
    tv.push_back(mk(0, CR, IOADDR, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 8'h33, 2'b00, 8'h00, 0, 0, 8'h00));     // 20 IN idx
    tv.push_back(idle(8'h33, 8'h00));                                                                               // 21
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 1, 0, 8'hFE, 0, 8'h77, 0, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h00));  // 22 aux rd
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 1, 0, 8'hFE, 0, 8'h77, 0, 1, 1, 8'hFF, 8'hFE, 2'b10, 8'h00, 1, 0, 8'h00));  // 23
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 1, 0, 8'hFE, 0, 8'h77, 0, 1, 1, 8'hFF, 8'hFE, 2'b10, 8'h00, 1, 1, 8'h00));  // 24 done
    tv.push_back(idle(8'h33, 8'h77));                                                                               // 25 rdata
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 1, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h77));  // 26 aux wr
    tv.push_back(mk(0, CW, IODATA, 8'h3C, 1, 1, 8'h10, 8'hA5, 0, 1, 1, 1, 8'hFF, 8'h10, 2'b01, 8'hA5, 1, 0, 8'h77)); // 27 + CPU OUT
    tv.push_back(mk(0, CW, IODATA, 8'h3C, 1, 1, 8'h10, 8'hA5, 0, 1, 1, 1, 8'hFF, 8'h10, 2'b00, 8'hA5, 1, 1, 8'h77)); // 28
    tv.push_back(mk(0, CW, IODATA, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 1, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h77)); // 29
    tv.push_back(mk(0, CW, IODATA, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 1, 1, 1, 8'hFF, 8'h33, 2'b01, 8'h3C, 0, 0, 8'h77)); // 30 CPU regwr
    tv.push_back(mk(0, CW, IODATA, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 1, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h77)); // 31
    tv.push_back(idle(8'h33, 8'h77));                                                                               // 32
    tv.push_back(idle(8'h33, 8'h77));                                                                               // 33
    tv.push_back(mk(0, CI, 16'h0, 8'h00, 1, 0, 8'h20, 0, 0, 1, 1, 1, 8'hFF, 8'h33, 2'b00, 8'h00, 0, 0, 8'h77));      // 34 aux rd
    tv.push_back(mk(1, CI, 16'h0, 8'h00, 1, 0, 8'h20, 0, 0, 1, 1, 1, 8'hFF, 8'h20, 2'b10, 8'h00, 1, 0, 8'h77));      // 35 rst in AUX_ADDR
    tv.push_back(idle(8'h00, 8'h00));                                                                               // 36 no done
    tv.push_back(idle(8'h00, 8'h00));                                                                               // 37
    tv.push_back(mk(0, CW, IODATA, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 8'h00, 0, 0, 8'h00));         // 38 OUT data
    tv.push_back(mk(0, CW, IODATA, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b01, 8'h66, 0, 0, 8'h00));         // 39
    tv.push_back(mk(1, CW, IODATA, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 8'h00, 0, 0, 8'h00));         // 40 rst
    tv.push_back(mk(0, CW, IODATA, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 8'h00, 0, 0, 8'h00));         // 41 no replay
    tv.push_back(mk(0, CW, IODATA, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 8'h00, 0, 0, 8'h00));         // 42
    tv.push_back(idle(8'h00, 8'h00));                                                                               // 43
    tv.push_back(idle(8'h00, 8'h00));                                                                               // 44

    tb_dir = 1'b1; d_rdout = 8'h00; d_roe = 1'b1;
    rst = 1'b1; cpu_a = 16'h0; cpu_din = 8'h00;
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
    @(posedge clk); #1; mon_en = 1'b1;

    for (int n = 0; n < tv.size(); n++) begin
      t = tv[n];
      @(posedge clk); #1;
      rst = t.rst; {cpu_iorq_n, cpu_rd_n, cpu_wr_n} = t.cpu; cpu_a = t.a; cpu_din = t.din;
      aux_req = t.areq; aux_we = t.awe; aux_addr = t.aaddr; aux_wdata = t.awd;
      d_rdout = t.rdout; d_roe = t.roe_n;
      @(negedge clk);
      if (t.chk) begin
        chk($sformatf("v%0d.cpu_oe_n", n), 16'(cpu_oe_n), 16'(t.e_oe_n));
        chk($sformatf("v%0d.cpu_dout", n), 16'(cpu_dout), 16'(t.e_dout));
        chk($sformatf("v%0d.zxuno_addr", n), 16'(zxuno_addr), 16'(t.e_zaddr));
        chk($sformatf("v%0d.rd_wr", n), 16'({zxuno_regrd, zxuno_regwr}), 16'(t.e_rdwr));
        chk($sformatf("v%0d.zxuno_dout", n), 16'(zxuno_dout), 16'(t.e_zdout));
        chk($sformatf("v%0d.aux_gnt", n), 16'(aux_gnt), 16'(t.e_gnt));
        chk($sformatf("v%0d.aux_done", n), 16'(aux_done), 16'(t.e_done));
        chk($sformatf("v%0d.aux_rdata", n), 16'(aux_rdata), 16'(t.e_ardata));
      end
    end

    // ---------------- randomized transactions ----------------
    @(posedge clk); #1;
    rst = 1'b1; tb_dir = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_idx = 8'h00;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 37 + 11);

    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 6);
      v  = 8'($urandom);
      v2 = 8'($urandom);
      ad = 8'($urandom);
      lw = $urandom_range(2, 4);
      lr = $urandom_range(2, 5);
      case (op)
        0: begin
          cpu_out(IOADDR, v, lw);
          m_idx = v;
        end
        1: begin
          cpu_out(IODATA, v, lw);
          wr_exp++;
          if (m_idx < 8'hC0) shadow[m_idx] = v;
        end
        2: begin
          cpu_in(IODATA, lr, rd, oe);
          chk("cpu_data_rd", 16'(rd), 16'(expv(m_idx)));
          chk("cpu_data_oe", 16'(oe), 16'd0);
        end
        3: begin
          cpu_in(IOADDR, lr, rd, oe);
          chk("cpu_idx_rd", 16'(rd), 16'(m_idx));
          chk("cpu_idx_oe", 16'(oe), 16'd0);
        end
        4: begin
          aux_op(1'b1, ad, v, rd, gn);
          wr_exp++;
          if (ad < 8'hC0) shadow[ad] = v;
          chk("aux_wr_gnt_cycles", 16'(gn), 16'd2);
        end
        5: begin
          aux_op(1'b0, ad, 8'h00, rd, gn);
          chk("aux_rd_data", 16'(rd), 16'(expv(ad)));
          chk("aux_rd_gnt_cycles", 16'(gn), 16'd2);
        end
        default: begin
          // Aux write in flight when a CPU data access arrives one cycle later.
          cw = 1'($urandom_range(0, 1));
          lw = $urandom_range(4, 6);
          wr_exp++;
          if (ad < 8'hC0) shadow[ad] = v;
          fork
            aux_op(1'b1, ad, v, rd, gn);
            begin
              @(posedge clk); #1;
              if (cw) cpu_out(IODATA, v2, lw);
              else    cpu_in(IODATA, lw, rd2, oe2);
            end
          join
          chk("conc_gnt_cycles", 16'(gn), 16'd2);
          if (cw) begin
            wr_exp++;
            if (m_idx < 8'hC0) shadow[m_idx] = v2;
          end else begin
            chk("conc_cpu_rd", 16'(rd2), 16'(expv(m_idx)));
            chk("conc_cpu_oe", 16'(oe2), 16'd0);
          end
        end
      endcase
      @(posedge clk); #1;
    end

    @(posedge clk); #1;
    chk("regwr_pulse_count", 16'(wr_seen), 16'(wr_exp));
    for (int i = 0; i < 192; i++) chk($sformatf("mem[%0h]", i), 16'(pmem[i]), 16'(shadow[i]));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
